// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl : arbitrates core fetch and load/store requests onto one
//                   synchronous single-port SRAM with req/ack handshakes.
// Revision        : 1.0
// ============================================================================
module mem_access_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ack,
  output logic [31:0]       instr,
  output logic              fetch_err,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [29:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_ack,
  output logic [31:0]       data_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_data,
  output logic              sram_wren,
  input  logic [31:0]       sram_q
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FETCH_WAIT = 2'd1,
    S_DATA_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_we;
  logic              r_fetch_err;
  logic [31:0]       r_instr;
  logic [31:0]       r_rdata;
  logic              w_fetch_err_d;
  logic              w_aligned;
  logic [ADDR_W-1:0] w_sram_address;
  logic [31:0]       w_sram_data;
  logic              w_sram_wren;

  // Address bits above the SRAM index are intentionally dropped (wrap).
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{fetch_addr[31:ADDR_W+2], data_addr[29:ADDR_W]};

  assign w_aligned = (fetch_addr[1:0] == 2'b00);

  always_comb begin
    w_next_state   = r_state;
    w_sram_address = '0;
    w_sram_data    = '0;
    w_sram_wren    = 1'b0;
    w_fetch_err_d  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_req) begin
          w_sram_address = data_addr[ADDR_W-1:0];
          w_sram_data    = data_wdata;
          // Gate with rst so a store racing an async reset never lands.
          w_sram_wren    = data_we & ~rst;
          w_next_state   = S_DATA_WAIT;
        end else if (fetch_req) begin
          if (w_aligned) begin
            w_sram_address = fetch_addr[ADDR_W+1:2];
            w_next_state   = S_FETCH_WAIT;
          end else begin
            w_fetch_err_d  = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_fetch_err <= 1'b0;
      r_instr     <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_fetch_err <= w_fetch_err_d;
      if (r_state == S_IDLE && data_req) begin
        r_we <= data_we;
      end
      if (r_state == S_FETCH_WAIT) begin
        r_instr <= sram_q;
      end
      if (r_state == S_DATA_WAIT && !r_we) begin
        r_rdata <= sram_q;
      end
    end
  end

  assign fetch_ack    = (r_state == S_FETCH_WAIT);
  assign data_ack     = (r_state == S_DATA_WAIT);
  assign busy         = (r_state != S_IDLE);
  assign fetch_err    = r_fetch_err;
  assign instr        = r_instr;
  assign data_rdata   = r_rdata;
  assign sram_address = w_sram_address;
  assign sram_data    = w_sram_data;
  assign sram_wren    = w_sram_wren;

endmodule
`default_nettype wire
